dp_arbiter: RTL
===============

DP_ARBITER -- requirements
Module: dp_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, meaning the maximum consecutive grant cycles before preemption; legal range 2..255.
REQ-002 Port clk input 1: rising-edge clock for all state.
REQ-003 Port reset input 1: synchronous, active-high reset.
REQ-004 Port req input 2: access requests; bit 0 is the fsm_controller, bit 1 is the debug/loader port.
REQ-005 Port write_in0 input 1: register-file write strobe from requester 0.
REQ-006 Port write_in1 input 1: register-file write strobe from requester 1.
REQ-007 Port writenum_in0 input 3: destination register from requester 0.
REQ-008 Port writenum_in1 input 3: destination register from requester 1.
REQ-009 Port gnt output 2: registered one-hot-or-zero grant.
REQ-010 Port write output 1: gated write strobe to the datapath.
REQ-011 Port writenum output 3: selected destination register to the datapath.
REQ-012 Port busy output 1: high whenever gnt is nonzero.
REQ-013 Port preempt output 1: one-cycle pulse on forced release.

Function
REQ-014 The state machine SHALL have states IDLE, OWN0 and OWN1; gnt SHALL be 00, 01 and 10 respectively.
REQ-015 gnt SHALL be registered: req rising in IDLE produces gnt on the following clock edge, a 1-cycle latency.
REQ-016 In IDLE with exactly one req bit high, the FSM SHALL move to the matching OWNx state.
REQ-017 In IDLE with both req bits high, the FSM SHALL grant the requester that is not last_owner (round-robin).
REQ-018 last_owner SHALL update on every entry to OWNx.
REQ-019 In OWNx with req[x] high, the FSM SHALL stay in OWNx, unless REQ-024 applies.
REQ-020 In OWNx with req[x] low and the other req high, the FSM SHALL move directly to OWN(other) with no IDLE bubble.
REQ-021 In OWNx with req[x] low and the other req low, the FSM SHALL move to IDLE.
REQ-022 write SHALL equal gnt[x] & req[x] & write_inx for the owner x, and SHALL be 0 in IDLE; a requester that has dropped req SHALL never write, even while gnt is still high.
REQ-023 writenum SHALL equal writenum_inx of the owner, and SHALL be 3'b000 in IDLE.
REQ-024 The hold counter SHALL:
- clear on each OWNx entry;
- increment each cycle in OWNx;
- saturate at MAX_HOLD-1;
- be 8 bits wide.
REQ-025 gnt SHALL never be 11 under any input sequence.
REQ-026 busy SHALL equal |gnt.

Reset
REQ-027 With reset high at a clock edge, the next state SHALL be IDLE: gnt=00, busy=0, preempt=0, hold counter=0, last_owner=1 (requester 0 wins the first tie).
REQ-028 write and writenum SHALL be 0 while gnt is 00.
REQ-029 Reset asserted mid-grant SHALL drop gnt on that edge regardless of req; no write SHALL occur in the cycle after.
REQ-030 Reset SHALL take priority over all transitions, including preemption.

Configuration
REQ-031 Macro DP_ARBITER_PREEMPT_EN, when defined, SHALL enable forced release: in OWNx with hold counter = MAX_HOLD-1 and the other req high, the FSM SHALL move to OWN(other) on the next edge and pulse preempt high for exactly that one cycle after the switch.
REQ-032 With DP_ARBITER_PREEMPT_EN defined, a preempted requester still holding req SHALL be re-granted only by the normal round-robin rules.
REQ-033 With DP_ARBITER_PREEMPT_EN undefined:
- the hold counter and preempt logic SHALL be absent;
- preempt SHALL be tied to 0;
- ownership SHALL last until req[x] drops.

Verification
REQ-034 Reset, then req=01 at cycle 0 -> gnt=01 at cycle 1, busy=1; write_in0=1, writenum_in0=3 -> write=1, writenum=3.
REQ-035 After reset, req=11 at cycle 0 -> gnt=01; req0 drops at cycle 4 -> gnt=10 at cycle 5 with no 00 cycle in between.
REQ-036 In OWN1, req=00 with write_in1=1 -> write=0 in that same cycle; gnt=00 on the next cycle.
REQ-037 OWN0 active, reset pulsed for 1 cycle while req=11 -> gnt=00 after the edge; then gnt=01, since last_owner=1.
REQ-038 With DP_ARBITER_PREEMPT_EN defined and MAX_HOLD=4, req=11 held -> gnt alternates 01x4, 10x4, 01x4; preempt pulses 1 on each switch cycle.
REQ-039 Same stimulus with the macro undefined -> gnt=01 indefinitely; preempt stays 0.

Source files
------------

// File: rtl/dp_arbiter.sv
// dp_arbiter: two-requester round-robin register-file write arbiter; define DP_ARBITER_PREEMPT_EN for forced release after MAX_HOLD cycles
module dp_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       write_in0,
  input  logic       write_in1,
  input  logic [2:0] writenum_in0,
  input  logic [2:0] writenum_in1,
  output logic [1:0] gnt,
  output logic       write,
  output logic [2:0] writenum,
  output logic       busy,
  output logic       preempt
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state, nxt;
  logic last_owner, own, stay, take;
`ifdef DP_ARBITER_PREEMPT_EN
  logic [7:0] hold;
`else
  assign preempt = 1'b0;
`endif
  always_comb begin
    own = state == OWN1;
`ifdef DP_ARBITER_PREEMPT_EN
    take = state != IDLE && hold == 8'(MAX_HOLD - 1) && req[!own];
`else
    take = 1'b0;
`endif
    stay = state != IDLE && req[own] && !take;
    nxt = state == IDLE ? (req == 2'b00 ? IDLE : req == 2'b01 ? OWN0 : req == 2'b10 ? OWN1 : last_owner ? OWN0 : OWN1)
        : stay ? state : req[!own] ? (own ? OWN0 : OWN1) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= 2'b00;
      last_owner <= 1'b1;
`ifdef DP_ARBITER_PREEMPT_EN
      hold       <= 8'd0;
      preempt    <= 1'b0;
`endif
    end else begin
      state <= nxt;
      gnt   <= {nxt == OWN1, nxt == OWN0};
      if (nxt != IDLE && nxt != state) last_owner <= nxt == OWN1;
`ifdef DP_ARBITER_PREEMPT_EN
      hold    <= (nxt == IDLE || nxt != state) ? 8'd0 : hold == 8'(MAX_HOLD - 1) ? hold : hold + 8'd1;
      preempt <= take;
`endif
    end
  end
  // a requester that has let go of req never writes, even with gnt still up
  assign write    = (gnt[0] & req[0] & write_in0) | (gnt[1] & req[1] & write_in1);
  assign writenum = gnt[0] ? writenum_in0 : gnt[1] ? writenum_in1 : 3'b000;
  assign busy     = |gnt;
endmodule
